serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit adder slice across a WIDTH-bit operand pair, one bit per clock, LSB first. It sits beside the ALU as a low-area add path for multi-cycle operations. Operands enter and results leave through valid/ready handshakes. The controller owns the carry flip-flop, the bit counter and the operand/result shift registers.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  controller can accept operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in, sampled with the operands.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_sum  output  WIDTH  result.
- o_cout  output  1  carry-out from bit WIDTH-1.
- o_busy  output  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready, latch i_a, i_b and i_cin into carry; clear counter; go to RUN.
- RUN, each cycle:
  - Slice inputs are a_sh[0], b_sh[0] and carry.
  - Slice sum shifts into sum_sh MSB; sum_sh shifts right.
  - a_sh and b_sh shift right.
  - Carry takes the slice carry-out.
  - Counter increments.
  - When counter==WIDTH-1, go to DONE.
- DONE:
  - o_valid=1, o_sum=sum_sh, o_cout=carry, all held stable.
  - On i_ready, go to IDLE.
- o_ready=0 in RUN and DONE. No overlap of accept and deliver: the earliest next accept is in the cycle after the result handshake.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.
- Arithmetic is modulo 2^WIDTH; o_cout is the true carry-out.
- One-bit slice: sum=a^b^c, cout=(a&b)|(c&(a^b)).

## Timing
- Reset value: state=IDLE. Internal registers are zero and every output is 0 except o_ready=1. Specifically o_ready=1, o_valid=0, o_sum=0, o_cout=0, o_busy=0.
- Latency: the accept handshake at edge k enters RUN. o_valid rises after edge k+WIDTH, i.e. WIDTH cycles.
- Throughput is at most one operation per WIDTH+2 cycles with i_ready tied high.
- Backpressure: DONE holds indefinitely while i_ready=0, with outputs unchanged.
- i_valid while busy is ignored; the source must hold it until o_ready.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values. The partial result is discarded, and no o_valid pulse follows deassertion.
- Operand inputs are don't-care outside the accept cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port i_sub (1 bit), sampled at accept.
  - When i_sub=1, b_sh is loaded with ~i_b and carry with 1, so the result is A-B.
  - o_cout=1 means no borrow.
  - i_cin is ignored when i_sub=1.
- SERIAL_ADDER_SUB_EN undefined: the i_sub port is absent and behaviour is add only.

## Structure
- Shared package serial_adder_pkg:
  - State enum type (IDLE/RUN/DONE), 2-bit encoding.
  - Default WIDTH localparam.
- Sub-module bit_slice_adder is the combinational one-bit full adder, built from two half-adder stages plus an OR for carry. It is instantiated once, and the controller drives it from the shift registers.

## Test plan
- WIDTH=8, A=0x0F, B=0x01, cin=0 -> after 8 cycles o_valid=1, o_sum=0x10, o_cout=0.
- A=0xFF, B=0x01, cin=0 -> o_sum=0x00, o_cout=1. A=0x7F, B=0x00, cin=1 -> o_sum=0x80, o_cout=0.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_sum/o_cout stable and o_ready=0 throughout. i_valid pulses during RUN are not accepted.
- Reset pulse at RUN cycle 3 -> all outputs at reset values next cycle. A new op A=0x01, B=0x02 then gives 0x03 with no stale o_valid.
- SERIAL_ADDER_SUB_EN: A=0x05, B=0x07, i_sub=1 -> o_sum=0xFE, o_cout=0. A=0x07, B=0x05 -> o_sum=0x02, o_cout=1.
- Back-to-back ops with i_valid and i_ready held high -> accepts spaced exactly WIDTH+2 cycles, with results in order.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and defaults for the bit-serial adder controller.
//   state_t       : controller FSM state (IDLE / RUN / DONE), 2-bit encoding
//   DEFAULT_WIDTH : default operand/result width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/bit_slice_adder.sv
// -----------------------------------------------------------------------------
// bit_slice_adder
// Combinational one-bit full adder built from two half-adder stages and an OR.
// Ports:
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   cout  : (a & b) | (c & (a ^ b))
// -----------------------------------------------------------------------------
module bit_slice_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    logic p;   // first half-adder sum (propagate)
    logic g1;  // first half-adder carry (generate)
    logic g2;  // second half-adder carry

    assign p    = a ^ b;
    assign g1   = a & b;
    assign sum  = p ^ c;
    assign g2   = p & c;
    assign cout = g1 | g2;

endmodule : bit_slice_adder

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder controller: one full-adder slice is stepped across a
// WIDTH-bit operand pair, LSB first, one bit per clock.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds input i_sub; with i_sub=1 the result is A-B
//   (B inverted, carry-in forced to 1, i_cin ignored, o_cout=1 => no borrow).
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_valid / o_ready  : operand handshake (i_a, i_b, i_cin [, i_sub])
//   o_valid / i_ready  : result handshake (o_sum, o_cout)
//   o_busy             : high while the serial add is running
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    bit_slice_adder u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Operand B and carry as loaded at accept; subtraction is A + ~B + 1.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        b_load   = i_b;
        cin_load = i_cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (i_sub) begin
            b_load   = ~i_b;
            cin_load = 1'b1;
        end
`endif
    end

    // The result shift register and carry are presented directly; they are
    // only meaningful (and held stable) while o_valid is high.
    assign o_sum  = sum_sh;
    assign o_cout = carry;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other one.
    // NOTE: the shift registers are reset too, since o_sum/o_cout expose them
    // and must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // o_ready is high throughout IDLE, so i_valid alone is the accept.
                    if (i_valid) begin
                        a_sh    <= i_a;
                        b_sh    <= b_load;
                        carry   <= cin_load;
                        sum_sh  <= '0;
                        cnt     <= '0;
                        state   <= RUN;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end

                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {slice_sum, sum_sh[WIDTH-1:1]};
                    carry  <= slice_cout;
                    // Stop on the last bit rather than wrapping the counter.
                    if (cnt == LAST) begin
                        state   <= DONE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_adder_ctrl
